led_pwm_array: RTL and testbench

Parametrised multi-channel LED driver replacing the free-running blink counter in the board tops. It runs on the PLL output clock, holds all LEDs dark until the PLL reports lock, and drives each active-low LED pin with per-channel PWM brightness in one of four modes: off, solid, blink or breathe. A valid/ready configuration port lets a controller (UART or CPU bridge) change any channel at run time, glitch-free at frame boundaries.

---
 rtl/led_pwm_array.sv | 230 +++++++++++++++++++++++
 tb/tb_led_pwm_array.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_array.sv
// Multi-channel active-low LED PWM driver with OFF/SOLID/BLINK/BREATHE modes.
// Counters run only while the PLL lock is present; config changes land on frame boundaries.
module led_pwm_array #(
   parameter int CHANNELS = 3,
   parameter int PWM_BITS = 8,
   parameter int PRESCALE = 98,
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clkin,
   input  logic                reset_n,
   input  logic                locked,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CW-1:0]       cfg_chan,
   input  logic [1:0]          cfg_mode,
   input  logic [PWM_BITS-1:0] cfg_duty,
   input  logic [15:0]         cfg_period,
   output logic [CHANNELS-1:0] led_n,
   output logic                frame_tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]       PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [PWM_BITS-1:0] PWM_MAX  = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] PWM_ZERO = {PWM_BITS{1'b0}};
   localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
   localparam logic [1:0] MODE_OFF     = 2'd0;
   localparam logic [1:0] MODE_SOLID   = 2'd1;
   localparam logic [1:0] MODE_BLINK   = 2'd2;
   localparam logic [1:0] MODE_BREATHE = 2'd3;

   // Returns {down, level} after one breathe step toward the peak or back toward zero.
   function automatic logic [PWM_BITS:0] breathe_step(input logic [PWM_BITS-1:0] level,
                                                      input logic                down,
                                                      input logic [PWM_BITS-1:0] peak);
      logic [PWM_BITS:0] r;
      r = {down, level};
      if (!down) begin
         if (level < peak)           r = {1'b0, level + PWM_ONE};
         else if (level != PWM_ZERO) r = {1'b1, level - PWM_ONE};
         else                        r = {1'b1, level};
      end else begin
         if (level != PWM_ZERO)      r = {1'b1, level - PWM_ONE};
         else if (peak != PWM_ZERO)  r = {1'b0, PWM_ONE};
         else                        r = {1'b0, level};
      end
      return r;
   endfunction

   logic [1:0]          rst_sync_q, lock_sync_q;
   logic                lock_s, accept_s, step_s, wrap_s;
   logic [PW-1:0]       pre_q, pre_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;

   logic [1:0]          act_mode_q [CHANNELS];
   logic [1:0]          act_mode_d [CHANNELS];
   logic [PWM_BITS-1:0] act_duty_q [CHANNELS];
   logic [PWM_BITS-1:0] act_duty_d [CHANNELS];
   logic [15:0]         act_per_q  [CHANNELS];
   logic [15:0]         act_per_d  [CHANNELS];
   logic [1:0]          stg_mode_q [CHANNELS];
   logic [1:0]          stg_mode_d [CHANNELS];
   logic [PWM_BITS-1:0] stg_duty_q [CHANNELS];
   logic [PWM_BITS-1:0] stg_duty_d [CHANNELS];
   logic [15:0]         stg_per_q  [CHANNELS];
   logic [15:0]         stg_per_d  [CHANNELS];
   logic [15:0]         fcnt_q     [CHANNELS];
   logic [15:0]         fcnt_d     [CHANNELS];
   logic [PWM_BITS-1:0] level_q    [CHANNELS];
   logic [PWM_BITS-1:0] level_d    [CHANNELS];
   logic [PWM_BITS-1:0] eff_s      [CHANNELS];
   logic [PWM_BITS:0]   bstep_s    [CHANNELS];
   logic [CHANNELS-1:0] pend_q, pend_d, phase_q, phase_d, down_q, down_d;
   logic [CHANNELS-1:0] wr_s, fdone_s, led_q, led_d;
   logic                tick_q;

   assign lock_s    = rst_sync_q[1] & lock_sync_q[1];
   assign accept_s  = cfg_valid & lock_s;
   assign step_s    = lock_s & (pre_q == PRE_LAST);
   assign wrap_s    = step_s & (pwm_q == PWM_MAX);
   assign cfg_ready = lock_s;
   assign led_n     = led_q;
   assign frame_tick = tick_q;

   // Reset-release and PLL-lock synchronisers.
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync_q  <= 2'b00;
         lock_sync_q <= 2'b00;
      end else begin
         rst_sync_q  <= {rst_sync_q[0], 1'b1};
         lock_sync_q <= {lock_sync_q[0], locked};
      end
   end

   // Prescaler and PWM step counter, both parked at zero without lock.
   always_comb begin
      pre_d = pre_q;
      pwm_d = pwm_q;
      if (!lock_s) begin
         pre_d = {PW{1'b0}};
         pwm_d = PWM_ZERO;
      end else if (pre_q == PRE_LAST) begin
         pre_d = {PW{1'b0}};
         pwm_d = pwm_q + PWM_ONE;
      end else begin
         pre_d = pre_q + PW'(1);
         pwm_d = pwm_q;
      end
   end

   // Per-channel decode: write strobe, frame-count expiry, breathe step, effective duty, pin level.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         wr_s[i]    = accept_s & (cfg_chan == CW'(i));
         fdone_s[i] = ({1'b0, fcnt_q[i]} + 17'd1) >=
                      {1'b0, (act_per_q[i] == 16'd0) ? 16'd1 : act_per_q[i]};
         bstep_s[i] = breathe_step(level_q[i], down_q[i], act_duty_q[i]);
         case (act_mode_q[i])
            MODE_OFF:     eff_s[i] = PWM_ZERO;
            MODE_SOLID:   eff_s[i] = act_duty_q[i];
            MODE_BLINK:   eff_s[i] = phase_q[i] ? act_duty_q[i] : PWM_ZERO;
            MODE_BREATHE: eff_s[i] = level_q[i];
            default:      eff_s[i] = PWM_ZERO;
         endcase
         led_d[i] = lock_s ? ~(pwm_q < eff_s[i]) : 1'b1;
      end
   end

   // Staging, frame-boundary apply and blink/breathe state updates.
   always_comb begin
      act_mode_d = act_mode_q;
      act_duty_d = act_duty_q;
      act_per_d  = act_per_q;
      stg_mode_d = stg_mode_q;
      stg_duty_d = stg_duty_q;
      stg_per_d  = stg_per_q;
      fcnt_d     = fcnt_q;
      level_d    = level_q;
      pend_d     = pend_q;
      phase_d    = phase_q;
      down_d     = down_q;
      for (int i = 0; i < CHANNELS; i++) begin
         if (wr_s[i]) begin
            stg_mode_d[i] = cfg_mode;
            stg_duty_d[i] = cfg_duty;
            stg_per_d[i]  = cfg_period;
         end else begin
            stg_mode_d[i] = stg_mode_q[i];
            stg_duty_d[i] = stg_duty_q[i];
            stg_per_d[i]  = stg_per_q[i];
         end
         // The value already pending applies now; a write on the boundary cycle waits a frame.
         pend_d[i] = (pend_q[i] & ~wrap_s) | wr_s[i];
         if (wrap_s && pend_q[i]) begin
            act_mode_d[i] = stg_mode_q[i];
            act_duty_d[i] = stg_duty_q[i];
            act_per_d[i]  = stg_per_q[i];
            fcnt_d[i]     = 16'd0;
            phase_d[i]    = 1'b1;
            level_d[i]    = PWM_ZERO;
            down_d[i]     = 1'b0;
         end else if (!lock_s) begin
            fcnt_d[i]  = 16'd0;
            phase_d[i] = 1'b1;
            level_d[i] = PWM_ZERO;
            down_d[i]  = 1'b0;
         end else if (wrap_s) begin
            case (act_mode_q[i])
               MODE_BLINK: begin
                  fcnt_d[i]  = fdone_s[i] ? 16'd0 : fcnt_q[i] + 16'd1;
                  phase_d[i] = fdone_s[i] ? ~phase_q[i] : phase_q[i];
               end
               MODE_BREATHE: begin
                  fcnt_d[i]  = fdone_s[i] ? 16'd0 : fcnt_q[i] + 16'd1;
                  level_d[i] = fdone_s[i] ? bstep_s[i][PWM_BITS-1:0] : level_q[i];
                  down_d[i]  = fdone_s[i] ? bstep_s[i][PWM_BITS] : down_q[i];
               end
               default: begin
                  fcnt_d[i] = 16'd0;
               end
            endcase
         end else begin
            fcnt_d[i] = fcnt_q[i];
         end
      end
   end

   // State registers.
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         pre_q   <= {PW{1'b0}};
         pwm_q   <= PWM_ZERO;
         pend_q  <= {CHANNELS{1'b0}};
         phase_q <= {CHANNELS{1'b1}};
         down_q  <= {CHANNELS{1'b0}};
         led_q   <= {CHANNELS{1'b1}};
         tick_q  <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            act_mode_q[i] <= MODE_OFF;
            act_duty_q[i] <= PWM_ZERO;
            act_per_q[i]  <= 16'd1;
            stg_mode_q[i] <= MODE_OFF;
            stg_duty_q[i] <= PWM_ZERO;
            stg_per_q[i]  <= 16'd1;
            fcnt_q[i]     <= 16'd0;
            level_q[i]    <= PWM_ZERO;
         end
      end else begin
         pre_q   <= pre_d;
         pwm_q   <= pwm_d;
         pend_q  <= pend_d;
         phase_q <= phase_d;
         down_q  <= down_d;
         led_q   <= led_d;
         tick_q  <= wrap_s;
         for (int i = 0; i < CHANNELS; i++) begin
            act_mode_q[i] <= act_mode_d[i];
            act_duty_q[i] <= act_duty_d[i];
            act_per_q[i]  <= act_per_d[i];
            stg_mode_q[i] <= stg_mode_d[i];
            stg_duty_q[i] <= stg_duty_d[i];
            stg_per_q[i]  <= stg_per_d[i];
            fcnt_q[i]     <= fcnt_d[i];
            level_q[i]    <= level_d[i];
         end
      end
   end

endmodule

// File: tb/tb_led_pwm_array.sv
// Directed bench for led_pwm_array with 3 channels, 4-bit PWM, prescale 2 (32-cycle frames).
module tb_led_pwm_array;

   localparam int CH = 3;
   localparam int FR = 32;

   logic        clkin = 1'b0;
   logic        reset_n, locked, cfg_valid, cfg_ready, frame_tick;
   logic [1:0]  cfg_chan, cfg_mode;
   logic [3:0]  cfg_duty;
   logic [15:0] cfg_period;
   logic [2:0]  led_n;

   int          n_checks = 0;
   int          n_fail = 0;
   int          lows [CH];
   logic [31:0] pat0;

   led_pwm_array #(.CHANNELS(3), .PWM_BITS(4), .PRESCALE(2)) dut (
      .clkin(clkin), .reset_n(reset_n), .locked(locked),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
      .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .cfg_period(cfg_period),
      .led_n(led_n), .frame_tick(frame_tick)
   );

   always #5 clkin = ~clkin;

   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode,
                            input logic [3:0] duty, input logic [15:0] per,
                            input logic exp_ready);
      cfg_valid = 1'b1; cfg_chan = ch; cfg_mode = mode; cfg_duty = duty; cfg_period = per;
      n_checks++;
      if (cfg_ready !== exp_ready) begin
         n_fail++;
         $display("FAIL cfg_ready_at_write: got %b, expected %b", cfg_ready, exp_ready);
      end
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic sync_frame();
      int k;
      k = 0;
      tick();
      while (frame_tick !== 1'b1 && k < 100) begin
         tick();
         k++;
      end
      n_checks++;
      if (frame_tick !== 1'b1) begin
         n_fail++;
         $display("FAIL sync_frame: frame_tick %b after %0d cycles, expected 1", frame_tick, k);
      end
   endtask

   // Samples one full frame starting at a frame_tick cycle; ends on the next frame_tick cycle.
   task automatic measure_frame();
      int extra;
      extra = 0;
      pat0 = 32'd0;
      for (int c = 0; c < CH; c++) lows[c] = 0;
      for (int k = 1; k <= FR; k++) begin
         tick();
         for (int c = 0; c < CH; c++) if (led_n[c] === 1'b0) lows[c]++;
         pat0[k-1] = ~led_n[0];
         if (k < FR && frame_tick !== 1'b0) extra++;
      end
      n_checks++;
      if (frame_tick !== 1'b1 || extra != 0) begin
         n_fail++;
         $display("FAIL frame_length: end tick %b, early ticks %0d, expected 1 and 0", frame_tick, extra);
      end
   endtask

   task automatic check_lows(input string name, input int c, input int exp);
      n_checks++;
      if (lows[c] != exp) begin
         n_fail++;
         $display("FAIL %s: ch%0d lit %0d cycles, expected %0d", name, c, lows[c], exp);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; locked = 1'b0; cfg_valid = 1'b0;
      cfg_chan = 2'd0; cfg_mode = 2'd0; cfg_duty = 4'd0; cfg_period = 16'd0;
      repeat (3) tick();
      n_checks++;
      if (led_n !== 3'b111 || frame_tick !== 1'b0 || cfg_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: led_n=%b tick=%b ready=%b, expected 111 0 0", led_n, frame_tick, cfg_ready);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_lock_gating();
      int bad;
      bad = 0;
      cfg_write(2'd0, 2'd1, 4'd8, 16'd1, 1'b0);
      repeat (40) begin
         tick();
         if (led_n !== 3'b111 || frame_tick !== 1'b0 || cfg_ready !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL unlocked_idle: %0d bad cycles, expected 0", bad);
      end
      locked = 1'b1;
      tick();
      n_checks++;
      if (cfg_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_lat1: got %b, expected 0", cfg_ready);
      end
      tick();
      n_checks++;
      if (cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_lat2: got %b, expected 1", cfg_ready);
      end
      sync_frame();
      measure_frame();
      check_lows("unlocked_write_ignored", 0, 0);
   endtask

   task automatic test_solid();
      logic [31:0] exp_pat;
      exp_pat = 32'h0000FFFF;
      sync_frame();
      cfg_write(2'd0, 2'd1, 4'd8, 16'd1, 1'b1);
      sync_frame();
      measure_frame();
      n_checks++;
      if (pat0 !== exp_pat) begin
         n_fail++;
         $display("FAIL solid8_pattern: got %h, expected %h", pat0, exp_pat);
      end
      check_lows("solid8_ch1", 1, 0);
      check_lows("solid8_ch2", 2, 0);
      sync_frame();
      cfg_write(2'd0, 2'd1, 4'd0, 16'd1, 1'b1);
      sync_frame();
      measure_frame();
      check_lows("solid0", 0, 0);
      sync_frame();
      cfg_write(2'd0, 2'd1, 4'd15, 16'd1, 1'b1);
      sync_frame();
      measure_frame();
      check_lows("solid15", 0, 30);
   endtask

   task automatic test_blink();
      int exp_b [9];
      exp_b = '{30, 30, 30, 0, 0, 0, 30, 30, 30};
      sync_frame();
      cfg_write(2'd1, 2'd2, 4'd15, 16'd3, 1'b1);
      sync_frame();
      for (int f = 0; f < 9; f++) begin
         measure_frame();
         check_lows("blink_ch1", 1, exp_b[f]);
         check_lows("blink_ch0_solid", 0, 30);
         check_lows("blink_ch2_off", 2, 0);
      end
   endtask

   task automatic test_breathe();
      int exp_l [10];
      exp_l = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
      sync_frame();
      cfg_write(2'd2, 2'd3, 4'd4, 16'd1, 1'b1);
      sync_frame();
      for (int f = 0; f < 10; f++) begin
         measure_frame();
         check_lows("breathe_ch2", 2, 2 * exp_l[f]);
      end
   endtask

   task automatic test_back_to_back();
      sync_frame();
      cfg_write(2'd1, 2'd0, 4'd0, 16'd1, 1'b1);
      cfg_write(2'd2, 2'd1, 4'd5, 16'd1, 1'b1);
      cfg_write(2'd0, 2'd1, 4'd2, 16'd1, 1'b1);
      cfg_write(2'd0, 2'd1, 4'd12, 16'd1, 1'b1);
      cfg_write(2'd3, 2'd1, 4'd15, 16'd1, 1'b1);
      sync_frame();
      measure_frame();
      check_lows("last_write_wins", 0, 24);
      check_lows("bad_chan_ch1", 1, 0);
      check_lows("bad_chan_ch2", 2, 10);
   endtask

   task automatic test_boundary_write();
      sync_frame();
      cfg_write(2'd0, 2'd1, 4'd4, 16'd1, 1'b1);
      repeat (30) tick();
      cfg_write(2'd0, 2'd1, 4'd10, 16'd1, 1'b1);
      n_checks++;
      if (frame_tick !== 1'b1) begin
         n_fail++;
         $display("FAIL boundary_align: frame_tick %b, expected 1", frame_tick);
      end
      measure_frame();
      check_lows("boundary_old_pending", 0, 8);
      measure_frame();
      check_lows("boundary_new_write", 0, 20);
   endtask

   task automatic test_lock_loss();
      int bad;
      int k;
      sync_frame();
      repeat (10) tick();
      locked = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (led_n !== 3'b111 || cfg_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL lock_loss_3cyc: led_n=%b ready=%b, expected 111 0", led_n, cfg_ready);
      end
      bad = 0;
      repeat (40) begin
         tick();
         if (led_n !== 3'b111 || frame_tick !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL lock_loss_hold: %0d bad cycles, expected 0", bad);
      end
      locked = 1'b1;
      k = 0;
      do begin
         tick();
         k++;
      end while (frame_tick !== 1'b1 && k < 100);
      n_checks++;
      if (k != 34) begin
         n_fail++;
         $display("FAIL relock_first_frame: first frame_tick after %0d cycles, expected 34", k);
      end
      measure_frame();
      check_lows("relock_ch0", 0, 20);
      check_lows("relock_ch1", 1, 0);
      check_lows("relock_ch2", 2, 10);
   endtask

   initial begin
      test_reset();
      test_lock_gating();
      test_solid();
      test_blink();
      test_breathe();
      test_back_to_back();
      test_boundary_write();
      test_lock_loss();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
